// File: rtl/micro_sequencer_if.sv
// Control-store / datapath bundle seen by the micro-sequencer.
// master = sequencer side, slave = control store + datapath + memory side.
interface micro_sequencer_if #(
   parameter int ADDR_W  = 11,
   parameter int UWORD_W = 41
);
   logic [UWORD_W-1:0] ROM_DATA;   // microword at ROM_ADDR
   logic [31:0]        IR;         // instruction register
   logic [3:0]         ALU_FLAGS;  // {n,z,v,c} from the ALU this cycle
   logic               MEM_READY;  // memory finishes the current RD/WR
   logic [ADDR_W-1:0]  ROM_ADDR;   // registered microaddress
   logic [3:0]         PSR_NZVC;   // registered condition codes
   logic               STALL;      // datapath must not commit this cycle
   logic               BUS_ERR;    // one-cycle memory-wait timeout pulse

   modport master (
      input  ROM_DATA, IR, ALU_FLAGS, MEM_READY,
      output ROM_ADDR, PSR_NZVC, STALL, BUS_ERR
   );

   modport slave (
      output ROM_DATA, IR, ALU_FLAGS, MEM_READY,
      input  ROM_ADDR, PSR_NZVC, STALL, BUS_ERR
   );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-sequencer: next-microaddress selection, NZVC register and the
// memory-wait stall / bus-error timeout handshake.
module micro_sequencer #(
   parameter int ADDR_W   = 11,
   parameter int UWORD_W  = 41,
   parameter int MAX_WAIT = 15
) (
   input  logic                CLOCK_50,
   input  logic                RESET_InHigh,
   micro_sequencer_if.master   bus
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_WAIT
   } state_t;

   // microword fields
   logic              f_rd;
   logic              f_wr;
   logic [3:0]        f_alu;
   logic [2:0]        f_cond;
   logic [ADDR_W-1:0] f_jaddr;

   assign f_rd    = bus.ROM_DATA[40];
   assign f_wr    = bus.ROM_DATA[39];
   assign f_alu   = bus.ROM_DATA[17:14];
   assign f_cond  = bus.ROM_DATA[13:11];
   assign f_jaddr = bus.ROM_DATA[10:0];

   // Register-file / mux fields and most of IR belong to the datapath;
   // they are reduced here only so the unused bits stay visible on purpose.
   logic unused_bits;
   assign unused_bits = ^{bus.ROM_DATA[38:18], bus.IR[29:25], bus.IR[18:14], bus.IR[12:0]};

   state_t            state;
   logic [ADDR_W-1:0] rom_addr;
   logic [ADDR_W-1:0] next_addr;
   logic [3:0]        psr;
   logic              bus_err;
   logic [CNT_W-1:0]  wait_cnt;

   logic mem_req;
   logic mem_stall;
   logic stall;
   logic psr_we;

   // RD and WR together are still a single access.
   assign mem_req   = f_rd | f_wr;
   assign mem_stall = mem_req & ~bus.MEM_READY;
   assign stall     = (state == S_INIT) | mem_stall;
   // ALU codes 0000..0011 are the condition-code setting operations.
   assign psr_we    = (f_alu[3:2] == 2'b00) & ~stall;

   // Next microaddress from COND/JADDR, registered flags, IR[13] and opcode decode.
   always_comb begin
      // NOTE: default first so every path assigns next_addr; otherwise a latch is inferred.
      next_addr = rom_addr + ADDR_W'(1);
      case (f_cond)
         3'b000: next_addr = rom_addr + ADDR_W'(1);
         3'b001: if (psr[3]) next_addr = f_jaddr;
         3'b010: if (psr[2]) next_addr = f_jaddr;
         3'b011: if (psr[1]) next_addr = f_jaddr;
         3'b100: if (psr[0]) next_addr = f_jaddr;
         3'b101: if (bus.IR[13]) next_addr = f_jaddr;
         3'b110: next_addr = f_jaddr;
         3'b111: begin
            if (bus.IR[31:30] != 2'b00)
               next_addr = {1'b1, bus.IR[31:30], bus.IR[24:19], 2'b00};
            else
               next_addr = {1'b1, 2'b00, bus.IR[24:22], 3'b000, 2'b00};
         end
         default: next_addr = rom_addr + ADDR_W'(1);
      endcase
   end

   // Sequencer FSM: INIT -> RUN, memory waits hold the address, timeout aborts to 0.
   always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
      if (RESET_InHigh) begin
         state    <= S_INIT;
         rom_addr <= '0;
         bus_err  <= 1'b0;
         wait_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         bus_err <= 1'b0;
         case (state)
            S_INIT: begin
               state <= S_RUN;
            end
            S_RUN: begin
               if (mem_stall)
                  state <= S_WAIT;
               else
                  rom_addr <= next_addr;
            end
            S_WAIT: begin
               if (bus.MEM_READY) begin
                  rom_addr <= next_addr;
                  wait_cnt <= '0;
                  state    <= S_RUN;
               end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                  // this is the MAX_WAIT-th wait cycle: abandon the access
                  rom_addr <= '0;
                  bus_err  <= 1'b1;
                  wait_cnt <= '0;
                  state    <= S_RUN;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= S_INIT;
            end
         endcase
      end
   end

   // Condition codes: load ALU flags on cc-setting ops when the datapath commits.
   always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
      if (RESET_InHigh)
         psr <= '0;
      else if (psr_we)
         psr <= bus.ALU_FLAGS;
   end

   assign bus.ROM_ADDR = rom_addr;
   assign bus.PSR_NZVC = psr;
   assign bus.STALL    = stall;
   assign bus.BUS_ERR  = bus_err;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: the stimulus process pushes the
// expected outputs for each cycle, a negedge monitor pops and compares.
module tb_micro_sequencer;

   localparam logic [3:0] NOP_ALU = 4'hF;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   micro_sequencer_if bus ();

   micro_sequencer dut (
      .CLOCK_50     (clk),
      .RESET_InHigh (rst),
      .bus          (bus)
   );

   typedef struct {
      int         stamp;
      string      name;
      logic [10:0] addr;
      logic [3:0]  psr;
      logic        stall;
      logic        berr;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_pass  = 0;
   int   n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [40:0] mw(input logic rd, input logic wr, input logic [3:0] alu,
                                      input logic [2:0] cond, input logic [10:0] jaddr);
      logic [40:0] w;
      w        = '0;
      w[40]    = rd;
      w[39]    = wr;
      w[17:14] = alu;
      w[13:11] = cond;
      w[10:0]  = jaddr;
      return w;
   endfunction

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
      n_total++;
      if (act === req)
         n_pass++;
      else
         $display("FAIL %s: got addr=%0d psr=%b stall=%b bus_err=%b, expected addr=%0d psr=%b stall=%b bus_err=%b",
                  name, act[16:6], act[5:2], act[1], act[0], req[16:6], req[5:2], req[1], req[0]);
   endtask

   // Monitor: compare the DUT against the expectation stamped for this cycle.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].stamp < cyc) begin
         e = sb.pop_front();
         n_total++;
         $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.stamp, cyc);
      end
      if (sb.size() > 0 && sb[0].stamp == cyc) begin
         e = sb.pop_front();
         check(e.name, {bus.ROM_ADDR, bus.PSR_NZVC, bus.STALL, bus.BUS_ERR},
                       {e.addr, e.psr, e.stall, e.berr});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [40:0] w, input logic [31:0] ir,
                        input logic [3:0] flags, input logic ready);
      bus.ROM_DATA  = w;
      bus.IR        = ir;
      bus.ALU_FLAGS = flags;
      bus.MEM_READY = ready;
   endtask

   task automatic expect_now(input string name, input logic [10:0] a, input logic [3:0] p,
                             input logic s, input logic b);
      sb.push_back('{stamp: cyc, name: name, addr: a, psr: p, stall: s, berr: b});
   endtask

   // Drive this cycle's inputs, record what the DUT must show during it, advance.
   task automatic step(input string name, input logic [10:0] a, input logic [3:0] p,
                       input logic s, input logic b, input logic [40:0] w,
                       input logic [31:0] ir, input logic [3:0] flags, input logic ready);
      drive(w, ir, flags, ready);
      expect_now(name, a, p, s, b);
      tick();
   endtask

   initial begin
      logic [40:0] nop;
      nop = mw(1'b0, 1'b0, NOP_ALU, 3'b000, 11'd0);
      drive(nop, 32'h0, 4'h0, 1'b0);
      tick();

      // reset and INIT: the cc-setting jump offered in INIT must be ignored
      step("reset_state", 11'd0, 4'b0000, 1'b1, 1'b0, nop, 32'h0, 4'h0, 1'b0);
      rst = 1'b0;
      step("init_cycle",  11'd0, 4'b0000, 1'b1, 1'b0, mw(0,0,4'h3,3'b110,11'd8), 32'h0, 4'b0100, 1'b0);
      step("run_first",   11'd0, 4'b0000, 1'b0, 1'b0, mw(0,0,4'h3,3'b110,11'd8), 32'h0, 4'b0100, 1'b0);

      // conditional jumps on registered flags
      step("jmp8_psr_z",  11'd8,  4'b0100, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b010,11'd12), 32'h0, 4'h0, 1'b0);
      step("z1_taken",    11'd12, 4'b0100, 1'b0, 1'b0, mw(0,0,4'h0,3'b110,11'd8),    32'h0, 4'h0, 1'b0);
      step("z_cleared",   11'd8,  4'b0000, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b010,11'd12), 32'h0, 4'h0, 1'b0);
      step("z0_fall",     11'd9,  4'b0000, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b110,11'd8),  32'h0, 4'h0, 1'b0);
      step("back_to_8",   11'd8,  4'b0000, 1'b0, 1'b0, mw(0,0,4'h3,3'b010,11'd12),    32'h0, 4'b0100, 1'b0);
      step("same_cyc_cc", 11'd9,  4'b0100, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b001,11'd100), 32'h0, 4'h0, 1'b0);
      step("n0_fall",     11'd10, 4'b0100, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b011,11'd100), 32'h0, 4'h0, 1'b0);
      step("v0_fall",     11'd11, 4'b0100, 1'b0, 1'b0, mw(0,0,4'h1,3'b001,11'd20),    32'h0, 4'b1011, 1'b0);
      step("psr_1011",    11'd12, 4'b1011, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b001,11'd20), 32'h0, 4'h0, 1'b0);
      step("n1_taken",    11'd20, 4'b1011, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b100,11'd30), 32'h0, 4'h0, 1'b0);
      step("c1_taken",    11'd30, 4'b1011, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b011,11'd40), 32'h0, 4'h0, 1'b0);
      step("v1_taken",    11'd40, 4'b1011, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b010,11'd50), 32'h0, 4'h0, 1'b0);
      step("z0_fall2",    11'd41, 4'b1011, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b101,11'd60), 32'h0000_2000, 4'h0, 1'b0);
      step("ir13_taken",  11'd60, 4'b1011, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b101,11'd70), 32'hFFFF_DFFF, 4'h0, 1'b0);

      // decode dispatch
      step("ir13_fall",   11'd61,   4'b1011, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b111,11'd0), 32'h8080_0000, 4'h0, 1'b0);
      step("decode_1600", 11'd1600, 4'b1011, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b111,11'd0), 32'h80B0_0000, 4'h0, 1'b0);
      step("decode_1624", 11'd1624, 4'b1011, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b111,11'd0), 32'h0280_0000, 4'h0, 1'b0);
      step("decode_1088", 11'd1088, 4'b1011, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b110,11'd1601), 32'h0, 4'h0, 1'b0);

      // unconditional jump to the top and increment wrap
      step("jmp_1601",    11'd1601, 4'b1011, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b110,11'd2047), 32'h0, 4'h0, 1'b0);
      step("jmp_2047",    11'd2047, 4'b1011, 1'b0, 1'b0, mw(0,0,NOP_ALU,3'b000,11'd0), 32'h0, 4'h0, 1'b0);
      step("wrap_to_0",   11'd0,    4'b1011, 1'b0, 1'b0, mw(0,0,4'h2,3'b110,11'd37), 32'h0, 4'b1010, 1'b0);

      // memory wait: the cc-setting read must not touch PSR while stalled
      step("mem_run",     11'd37, 4'b1010, 1'b1, 1'b0, mw(1,0,4'h0,3'b000,11'd0), 32'h0, 4'b0000, 1'b0);
      step("mem_wait1",   11'd37, 4'b1010, 1'b1, 1'b0, mw(1,0,4'h0,3'b000,11'd0), 32'h0, 4'b0000, 1'b0);
      step("mem_wait2",   11'd37, 4'b1010, 1'b1, 1'b0, mw(1,0,4'h0,3'b000,11'd0), 32'h0, 4'b0000, 1'b0);
      step("mem_ready",   11'd37, 4'b1010, 1'b0, 1'b0, mw(1,0,4'h0,3'b000,11'd0), 32'h0, 4'b0110, 1'b1);
      // MEM_READY with no access pending is ignored
      step("mem_done",    11'd38, 4'b0110, 1'b0, 1'b0, nop, 32'h0, 4'h0, 1'b1);

      // write timeout: 15 wait cycles, then BUS_ERR pulse and restart at 0
      step("to_run",      11'd39, 4'b0110, 1'b1, 1'b0, mw(0,1,4'h0,3'b110,11'd500), 32'h0, 4'h0, 1'b0);
      for (int k = 1; k <= 15; k++)
         step($sformatf("to_wait%0d", k), 11'd39, 4'b0110, 1'b1, 1'b0,
              mw(0,1,4'h0,3'b110,11'd500), 32'h0, 4'h0, 1'b0);
      step("bus_err",     11'd0, 4'b0110, 1'b0, 1'b1, nop, 32'h0, 4'h0, 1'b0);
      step("bus_err_end", 11'd1, 4'b0110, 1'b0, 1'b0, mw(0,0,4'h2,3'b110,11'd37), 32'h0, 4'b1010, 1'b0);

      // reset asserted mid-WAIT, dual RD+WR access
      step("dual_req",    11'd37, 4'b1010, 1'b1, 1'b0, mw(1,1,NOP_ALU,3'b000,11'd0), 32'h0, 4'h0, 1'b0);
      step("dual_wait",   11'd37, 4'b1010, 1'b1, 1'b0, mw(1,1,NOP_ALU,3'b000,11'd0), 32'h0, 4'h0, 1'b0);
      rst = 1'b1;
      expect_now("rst_async", 11'd0, 4'b0000, 1'b1, 1'b0);
      tick();
      expect_now("rst_hold",  11'd0, 4'b0000, 1'b1, 1'b0);
      tick();
      rst = 1'b0;
      step("rst_init",    11'd0, 4'b0000, 1'b1, 1'b0, nop, 32'h0, 4'h0, 1'b0);
      step("rst_run",     11'd0, 4'b0000, 1'b0, 1'b0, nop, 32'h0, 4'h0, 1'b0);
      step("rst_inc",     11'd1, 4'b0000, 1'b0, 1'b0, nop, 32'h0, 4'h0, 1'b0);

      // drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      #1;
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_total++;
         $display("FAIL %s: expectation for cycle %0d left unchecked", e.name, e.stamp);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Control-section sequencer that drives the 11-bit address into the combinational microcode control store and consumes the returned 41-bit microword.
- Computes the next microaddress from the COND/JADDR fields, the condition-code register, IR[13], and instruction decode.
- Owns the NZVC condition-code register and the memory-wait stall handshake.
- Sits between the control store and the datapath. Its STALL output gates datapath register writes.

Parameters:
- ADDR_W, 11, control-store address width.
- UWORD_W, 41, microword width.
- MAX_WAIT, 15, maximum consecutive memory-wait cycles before a bus-error abort.

Ports:
- CLOCK_50  input  1  system clock; all state updates on the rising edge.
- RESET_InHigh  input  1  asynchronous, active-high reset.
- ROM_DATA  input  41  microword for the current ROM_ADDR. Fields: RD[40], WR[39], A[38:33], AMUX[32], B[31:26], BMUX[25], C[24:19], CMUX[18], ALU[17:14], COND[13:11], JADDR[10:0].
- IR  input  32  instruction register contents.
- ALU_FLAGS  input  4  {n,z,v,c} produced by the ALU this cycle.
- MEM_READY  input  1  memory completes the current RD/WR this cycle.
- ROM_ADDR  output  11  registered microaddress (CSAI) to the control store.
- PSR_NZVC  output  4  registered condition codes.
- STALL  output  1  datapath must not commit register/flag writes this cycle.
- BUS_ERR  output  1  one-cycle pulse on memory-wait timeout.

Behaviour:
- Reset (async, while RESET_InHigh=1):
  - ROM_ADDR=0, PSR_NZVC=0, BUS_ERR=0, wait counter=0, state=INIT.
  - STALL=1 while in INIT.
- FSM states: INIT, RUN, WAIT.
  - INIT: one cycle after reset release, then go to RUN. ROM_ADDR stays 0.
  - RUN: if (RD|WR)=1 and MEM_READY=0, go to WAIT and hold ROM_ADDR. Otherwise load the next address.
  - WAIT: hold ROM_ADDR and increment the wait counter.
    - If MEM_READY=1: load the next address, clear the counter, go to RUN.
    - If the counter reaches MAX_WAIT with MEM_READY still 0: ROM_ADDR<=0, BUS_ERR=1 for one cycle, counter cleared, go to RUN.
- STALL (combinational) = (state==INIT) | ((RD|WR) & ~MEM_READY).
- Next address, selected by COND:
  - 000: ROM_ADDR+1, modulo 2^11 (2047 wraps to 0).
  - 001/010/011/100: JADDR if PSR n/z/v/c respectively is 1, else +1.
  - 101: JADDR if IR[13]=1, else +1.
  - 110: JADDR unconditionally.
  - 111 decode:
    - IR[31:30]!=00: {1'b1, IR[31:30], IR[24:19], 2'b00}.
    - IR[31:30]==00: {1'b1, 2'b00, IR[24:22], 3'b000, 2'b00} (disp bits ignored).
- Condition-flag timing:
  - Conditional jumps use the registered PSR value, not the value updated at the same edge.
  - PSR update: PSR<=ALU_FLAGS when ALU field is 0000..0011 (cc-setting ops) and STALL=0. Otherwise hold.
- Simultaneous events:
  - RD and WR both set: treated as one memory access (same wait rule).
  - MEM_READY high with RD=WR=0: ignored.
- Reset asserted mid-WAIT aborts the access and returns to the reset values above.

Test Plan:
- Reset: assert RESET_InHigh mid-WAIT while ROM_ADDR=37, PSR=1010 -> ROM_ADDR=0, PSR=0000, STALL=1 immediately. After release: one INIT cycle with STALL=1, then RUN.
- Decode, COND=111:
  - IR=0x80800000 -> ROM_ADDR=1600.
  - IR=0x80B00000 -> ROM_ADDR=1624.
  - IR=0x02800000 -> ROM_ADDR=1088.
- Conditional jump, COND=010, JADDR=12, ROM_ADDR=8:
  - PSR z=1 -> 12.
  - PSR z=0 -> 9.
  - Same-cycle ALU=0011 with flags z=1 and PSR z=0 -> 9, and PSR becomes 0100.
- Increment wrap: ROM_ADDR=2047, COND=000 -> 0. COND=110, JADDR=2047 from address 1601 -> 2047.
- Memory wait: RD=1, MEM_READY low for 3 cycles -> ROM_ADDR held, STALL=1 for 3 cycles, PSR unchanged. MEM_READY high -> STALL=0, next address taken, state RUN.
- Timeout: WR=1, MEM_READY held 0 -> after 15 WAIT cycles BUS_ERR pulses one cycle, ROM_ADDR=0, counter=0.
